// File: rtl/pkt_majority_voter.sv
// pkt_majority_voter: receives three redundant copies of a packet segment from
// a byte stream, forms the bitwise 2-of-3 majority, packs it into 256-bit words
// and writes them to the memory-controller write port. Single clock (dclk).
// Ports:
//   dclk, RST                 clock, asynchronous active-high reset
//   rx_data, rx_en            received byte stream, rx_en frames one packet
//   wr_busy                   write port busy (no write accepted while high)
//   wr_en, wr_addr, wr_data   write strobe, address, voted word (byte 0 at MSB)
//   rd_*                      read port, reserved: inputs ignored, outputs 0
module pkt_majority_voter #(
    parameter int unsigned WHEREIS_SEGNUM = 34,
    parameter int unsigned WHEREIS_ID     = 36,
    parameter int unsigned PKT_MAX        = 128
) (
    input  logic         dclk,
    input  logic         RST,
    input  logic [7:0]   rx_data,
    input  logic         rx_en,
    input  logic         wr_busy,
    output logic         wr_en,
    output logic [24:0]  wr_addr,
    output logic [255:0] wr_data,
    input  logic         rd_busy,
    input  logic [255:0] rd_data,
    input  logic         rd_data_valid,
    output logic         rd_en,
    output logic [24:0]  rd_addr
);
    localparam int unsigned LW = $clog2(PKT_MAX + 1);
    localparam int unsigned BW = $clog2(PKT_MAX);
    localparam logic [LW-1:0] MAX_L  = LW'(PKT_MAX);
    localparam logic [LW-1:0] SEG_HI = LW'(WHEREIS_SEGNUM);
    localparam logic [LW-1:0] SEG_LO = LW'(WHEREIS_SEGNUM + 1);
    localparam logic [LW-1:0] ID_IDX = LW'(WHEREIS_ID);
    localparam logic [2:0]    FIFO_FULL = 3'd4;

    typedef enum logic {S_IDLE, S_VOTE} state_t;

    // Four byte buffers: three owned by slots, one used as RX staging; commit swaps ownership.
    logic [7:0]    mem_q [4][PKT_MAX];
    logic [1:0]    slot_buf_q [3];
    logic [1:0]    slot_buf_d [3];
    logic [1:0]    stg_q, stg_d;
    logic [LW-1:0] len_q [3];
    logic [LW-1:0] len_d [3];
    logic [2:0]    valid_q, valid_d;
    logic [15:0]   set_seg_q, set_seg_d;

    logic          rx_en_q, acc_q;
    logic [LW-1:0] n_q, idx_c;
    logic [15:0]   seg_stg_q;
    logic [3:0]    id_stg_q;
    logic          rx_start_c, rx_close_c, can_accept_c, commit_c;
    logic [1:0]    slot_c;

    state_t        state_q, state_d;
    logic [LW-1:0] k_q, k_d, lim_q, lim_d, maxlen_c, lim_round_c;
    logic [LW:0]   lim_ext_c;
    logic [247:0]  word_q, word_d;
    logic [7:0]    op_c [3];
    logic [7:0]    vote_byte_c;

    logic [255:0]  fdat_q [4];
    logic [24:0]   fadr_q [4];
    logic [1:0]    wp_q, rp_q;
    logic [2:0]    cnt_q;
    logic          push_c, pop_c;
    logic [255:0]  push_data_c, last_data_q;
    logic [24:0]   push_addr_c, last_addr_q;

    logic          unused_c;
    assign unused_c = ^{rd_busy, rd_data, rd_data_valid};
    assign rd_en    = 1'b0;
    assign rd_addr  = '0;

    // RX framing and packet acceptance
    assign rx_start_c   = rx_en & ~rx_en_q;
    assign rx_close_c   = ~rx_en & rx_en_q;
    assign idx_c        = rx_start_c ? '0 : n_q;
    assign can_accept_c = (state_q == S_IDLE) && (cnt_q == 3'd0) && !(&valid_q);
    assign commit_c     = rx_close_c && acc_q && (n_q > ID_IDX) &&
                          (id_stg_q >= 4'd1) && (id_stg_q <= 4'd3);
    assign slot_c       = 2'(id_stg_q - 4'd1);

    // Voting operands: bytes beyond a copy's length read as zero
    always_comb begin
        for (int x = 0; x < 3; x++) begin
            op_c[x] = (k_q < len_q[x]) ? mem_q[slot_buf_q[x]][k_q[BW-1:0]] : 8'h00;
        end
        vote_byte_c = (op_c[0] & op_c[1]) | (op_c[0] & op_c[2]) | (op_c[1] & op_c[2]);
    end

    // Vote length: longest copy rounded up to a whole word
    always_comb begin
        maxlen_c    = (len_q[0] > len_q[1]) ? len_q[0] : len_q[1];
        maxlen_c    = (len_q[2] > maxlen_c) ? len_q[2] : maxlen_c;
        lim_ext_c   = {1'b0, maxlen_c} + (LW+1)'(31);
        lim_round_c = LW'(lim_ext_c & ~(LW+1)'(31));
    end

    assign push_data_c = {word_q, vote_byte_c};
    assign push_addr_c = {4'b0000, set_seg_q, 2'(k_q >> 5), 3'b000};

    // Next-state: slot commit and vote sequencing
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        lim_d      = lim_q;
        word_d     = word_q;
        valid_d    = valid_q;
        set_seg_d  = set_seg_q;
        len_d      = len_q;
        slot_buf_d = slot_buf_q;
        stg_d      = stg_q;
        push_c     = 1'b0;

        if (commit_c) begin
            if (seg_stg_q != set_seg_q) valid_d = '0;
            set_seg_d          = seg_stg_q;
            valid_d[slot_c]    = 1'b1;
            len_d[slot_c]      = n_q;
            slot_buf_d[slot_c] = stg_q;
            stg_d              = slot_buf_q[slot_c];
        end

        case (state_q)
            S_IDLE: begin
                if (&valid_q) begin
                    state_d = S_VOTE;
                    k_d     = '0;
                    lim_d   = lim_round_c;
                end
            end
            S_VOTE: begin
                if (cnt_q != FIFO_FULL) begin
                    word_d = push_data_c[247:0];
                    k_d    = k_q + LW'(1);
                    push_c = (k_q[4:0] == 5'd31);
                    if (k_q == lim_q - LW'(1)) begin
                        state_d = S_IDLE;
                        valid_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Write port: pop the FIFO head whenever the port is free
    assign pop_c   = (cnt_q != 3'd0) && !wr_busy;
    assign wr_en   = pop_c;
    assign wr_data = pop_c ? fdat_q[rp_q] : last_data_q;
    assign wr_addr = pop_c ? fadr_q[rp_q] : last_addr_q;

    // Buffer and FIFO storage (contents are meaningless until tracked valid)
    always_ff @(posedge dclk) begin
        if (rx_en && (idx_c < MAX_L)) mem_q[stg_q][idx_c[BW-1:0]] <= rx_data;
        if (push_c) begin
            fdat_q[wp_q] <= push_data_c;
            fadr_q[wp_q] <= push_addr_c;
        end
    end

    // State registers
    always_ff @(posedge dclk or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            lim_q       <= '0;
            word_q      <= '0;
            valid_q     <= '0;
            set_seg_q   <= '0;
            stg_q       <= 2'd3;
            for (int x = 0; x < 3; x++) begin
                len_q[x]      <= '0;
                slot_buf_q[x] <= 2'(x);
            end
            rx_en_q     <= 1'b0;
            acc_q       <= 1'b0;
            n_q         <= '0;
            seg_stg_q   <= '0;
            id_stg_q    <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            last_data_q <= '0;
            last_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            lim_q      <= lim_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            set_seg_q  <= set_seg_d;
            stg_q      <= stg_d;
            len_q      <= len_d;
            slot_buf_q <= slot_buf_d;
            rx_en_q    <= rx_en;
            if (rx_start_c) acc_q <= can_accept_c;
            if (rx_en) begin
                n_q <= (idx_c < MAX_L) ? idx_c + LW'(1) : idx_c;
                if (idx_c == SEG_HI) seg_stg_q[15:8] <= rx_data;
                if (idx_c == SEG_LO) seg_stg_q[7:0]  <= rx_data;
                if (idx_c == ID_IDX) id_stg_q        <= rx_data[3:0];
            end
            if (push_c) wp_q <= wp_q + 2'd1;
            if (pop_c) begin
                rp_q        <= rp_q + 2'd1;
                last_data_q <= fdat_q[rp_q];
                last_addr_q <= fadr_q[rp_q];
            end
            cnt_q <= cnt_q + 3'(push_c) - 3'(pop_c);
        end
    end

endmodule

// File: tb/tb_pkt_majority_voter.sv
// Directed testbench for pkt_majority_voter with a small reference model of
// the packet pattern and the 2-of-3 vote.
module tb_pkt_majority_voter;
    logic         dclk = 1'b0;
    logic         RST;
    logic [7:0]   rx_data;
    logic         rx_en;
    logic         wr_busy;
    logic         wr_en;
    logic [24:0]  wr_addr;
    logic [255:0] wr_data;
    logic         rd_en;
    logic [24:0]  rd_addr;

    int checks = 0;
    int errors = 0;
    int busy_viol = 0;
    logic [24:0]  wa_q[$];
    logic [255:0] wd_q[$];

    pkt_majority_voter dut (
        .dclk(dclk), .RST(RST), .rx_data(rx_data), .rx_en(rx_en),
        .wr_busy(wr_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_busy(1'b0), .rd_data(256'd0), .rd_data_valid(1'b0),
        .rd_en(rd_en), .rd_addr(rd_addr)
    );

    always #5 dclk = ~dclk;

    // Record every accepted write
    always @(negedge dclk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            if (wr_busy) busy_viol++;
        end
    end

    function automatic logic [7:0] pkt_byte(input int i, input int id, input logic [15:0] seg);
        if (i == 34)       return seg[15:8];
        else if (i == 35)  return seg[7:0];
        else if (i == 36)  return 8'(id);
        else if (i == 100) return 8'hAA;
        else               return 8'(i + id);
    endfunction

    function automatic logic [255:0] exp_word(input logic [15:0] seg, input int len, input int w);
        logic [255:0] r;
        logic [7:0] a, b, c;
        r = '0;
        for (int j = 0; j < 32; j++) begin
            a = (w*32 + j < len) ? pkt_byte(w*32 + j, 1, seg) : 8'h00;
            b = (w*32 + j < len) ? pkt_byte(w*32 + j, 2, seg) : 8'h00;
            c = (w*32 + j < len) ? pkt_byte(w*32 + j, 3, seg) : 8'h00;
            r[255 - 8*j -: 8] = (a & b) | (a & c) | (b & c);
        end
        return r;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge dclk);
        #1;
    endtask

    task automatic send_pkt(input logic [15:0] seg, input int id, input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge dclk); #1;
            rx_en   = 1'b1;
            rx_data = pkt_byte(i, id, seg);
        end
        @(posedge dclk); #1;
        rx_en = 1'b0;
    endtask

    task automatic send_ids(input logic [15:0] seg, input int first, input int last, input int len);
        for (int id = first; id <= last; id++) send_pkt(seg, id, len);
    endtask

    task automatic clear_log;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset;
        RST = 1'b1; rx_en = 1'b0; rx_data = '0; wr_busy = 1'b0;
        cycles(3);
        @(negedge dclk);
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 25'd0) begin errors++; $display("FAIL reset_wr_addr got %h exp 0", wr_addr); end
        checks++; if (wr_data !== '0)    begin errors++; $display("FAIL reset_wr_data got %h exp 0", wr_data); end
        checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
        checks++; if (rd_addr !== 25'd0) begin errors++; $display("FAIL reset_rd_addr got %h exp 0", rd_addr); end
        RST = 1'b0;
        cycles(2);
    endtask

    task automatic test_basic;
        clear_log();
        send_ids(16'd0, 1, 5, 101);
        cycles(200);
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wa_q[w] !== 25'(w*8)) begin errors++; $display("FAIL basic_addr%0d got %0d exp %0d", w, wa_q[w], w*8); end
            checks++; if (wd_q[w] !== exp_word(16'd0, 101, w)) begin errors++; $display("FAIL basic_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd0, 101, w)); end
        end
        if (wd_q.size() >= 4) begin
            checks++; if (wd_q[0][255:248] !== 8'h03) begin errors++; $display("FAIL basic_byte0 got %h exp 03", wd_q[0][255:248]); end
            checks++; if (wd_q[0][247:240] !== 8'h02) begin errors++; $display("FAIL basic_byte1 got %h exp 02", wd_q[0][247:240]); end
            checks++; if (wd_q[1][255-8*4 -: 8] !== 8'h03) begin errors++; $display("FAIL basic_byte36 got %h exp 03", wd_q[1][255-8*4 -: 8]); end
            checks++; if (wd_q[3][255-8*4 -: 8] !== 8'hAA) begin errors++; $display("FAIL basic_byte100 got %h exp aa", wd_q[3][255-8*4 -: 8]); end
            checks++; if (wd_q[3][255-8*5:0] !== '0) begin errors++; $display("FAIL basic_tail got %h exp 0", wd_q[3][255-8*5:0]); end
        end
    endtask

    task automatic test_seq;
        clear_log();
        for (int s = 0; s < 5; s++) begin
            send_ids(16'(s), 1, 5, 101);
            cycles(200);
        end
        checks++; if (wa_q.size() != 20) begin errors++; $display("FAIL seq_count got %0d exp 20", wa_q.size()); end
        for (int i = 0; i < wa_q.size() && i < 20; i++) begin
            checks++; if (wa_q[i] !== 25'(i*8)) begin errors++; $display("FAIL seq_addr%0d got %0d exp %0d", i, wa_q[i], i*8); end
            checks++; if (wd_q[i] !== exp_word(16'(i/4), 101, i%4)) begin errors++; $display("FAIL seq_data%0d got %h exp %h", i, wd_q[i], exp_word(16'(i/4), 101, i%4)); end
        end
    endtask

    task automatic test_busy;
        clear_log();
        busy_viol = 0;
        wr_busy = 1'b1;
        send_ids(16'd5, 1, 3, 101);
        cycles(200);
        send_ids(16'd6, 1, 3, 101);
        cycles(200);
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL busy_held got %0d writes exp 0", wa_q.size()); end
        wr_busy = 1'b0;
        cycles(50);
        checks++; if (busy_viol != 0) begin errors++; $display("FAIL busy_violation got %0d exp 0", busy_viol); end
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL busy_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wa_q[w] !== 25'(160 + w*8)) begin errors++; $display("FAIL busy_addr%0d got %0d exp %0d", w, wa_q[w], 160 + w*8); end
            checks++; if (wd_q[w] !== exp_word(16'd5, 101, w)) begin errors++; $display("FAIL busy_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd5, 101, w)); end
        end
    endtask

    task automatic test_partial;
        clear_log();
        send_ids(16'd7, 1, 2, 101);
        cycles(200);
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL partial_seg7 got %0d writes exp 0", wa_q.size()); end
        send_ids(16'd8, 1, 3, 101);
        cycles(200);
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL partial_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wa_q[w] !== 25'(256 + w*8)) begin errors++; $display("FAIL partial_addr%0d got %0d exp %0d", w, wa_q[w], 256 + w*8); end
            checks++; if (wd_q[w] !== exp_word(16'd8, 101, w)) begin errors++; $display("FAIL partial_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd8, 101, w)); end
        end
    endtask

    task automatic test_short_and_trunc;
        clear_log();
        send_ids(16'd9, 1, 2, 101);
        send_pkt(16'd9, 3, 30);
        cycles(100);
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL short_dropped got %0d writes exp 0", wa_q.size()); end
        send_pkt(16'd9, 3, 101);
        cycles(200);
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL short_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wd_q[w] !== exp_word(16'd9, 101, w)) begin errors++; $display("FAIL short_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd9, 101, w)); end
        end
        clear_log();
        send_ids(16'd10, 1, 3, 200);
        cycles(200);
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL trunc_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wa_q[w] !== 25'(320 + w*8)) begin errors++; $display("FAIL trunc_addr%0d got %0d exp %0d", w, wa_q[w], 320 + w*8); end
            checks++; if (wd_q[w] !== exp_word(16'd10, 128, w)) begin errors++; $display("FAIL trunc_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd10, 128, w)); end
        end
    endtask

    task automatic test_reset_mid_vote;
        clear_log();
        send_ids(16'd11, 1, 3, 101);
        cycles(60);
        checks++; if (wa_q.size() == 0) begin errors++; $display("FAIL midrst_prewrite got %0d writes exp >0", wa_q.size()); end
        RST = 1'b1;
        @(negedge dclk);
        clear_log();
        checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL midrst_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 25'd0) begin errors++; $display("FAIL midrst_wr_addr got %h exp 0", wr_addr); end
        checks++; if (wr_data !== '0)    begin errors++; $display("FAIL midrst_wr_data got %h exp 0", wr_data); end
        cycles(2);
        RST = 1'b0;
        cycles(200);
        checks++; if (wa_q.size() != 0) begin errors++; $display("FAIL midrst_after got %0d writes exp 0", wa_q.size()); end
        send_ids(16'd12, 1, 3, 101);
        cycles(200);
        checks++; if (wa_q.size() != 4) begin errors++; $display("FAIL midrst_count got %0d exp 4", wa_q.size()); end
        for (int w = 0; w < wa_q.size() && w < 4; w++) begin
            checks++; if (wa_q[w] !== 25'(384 + w*8)) begin errors++; $display("FAIL midrst_addr%0d got %0d exp %0d", w, wa_q[w], 384 + w*8); end
            checks++; if (wd_q[w] !== exp_word(16'd12, 101, w)) begin errors++; $display("FAIL midrst_data%0d got %h exp %h", w, wd_q[w], exp_word(16'd12, 101, w)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq();
        test_busy();
        test_partial();
        test_short_and_trunc();
        test_reset_mid_vote();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
